// File: rtl/fft_twiddle_seq.sv
// Twiddle-factor sequencer for one radix-2 DIT butterfly stage: streams the N/2 twiddles
// in butterfly order over valid/ready. The W_N^k table is built at elaboration, so no image file is needed.
module fft_twiddle_seq #(
  parameter int N_POINTS = 8,
  parameter int LOG2N    = 3,
  parameter int W_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LOG2N-1:0]          stage,
  input  logic                      inverse,
  input  logic                      w_ready,
  output logic                      w_valid,
  output logic signed [W_WIDTH-1:0] w_real,
  output logic signed [W_WIDTH-1:0] w_imag,
  output logic [LOG2N-2:0]          w_index,
  output logic                      w_last,
  output logic                      busy,
  output logic                      done
);

  localparam int HALF = N_POINTS / 2;
  localparam int KW   = LOG2N - 1;
  localparam int FRAC = 30;
  localparam longint ONE_Q30 = 64'sd1073741824;
  localparam longint PI_Q30  = 64'sd3373259426;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  typedef logic [HALF-1:0][2*W_WIDTH-1:0] rom_t;

  // Q30 Taylor series on [0, pi/2); the second quadrant uses the quarter-turn identity
  function automatic rom_t build_rom();
    rom_t   rom;
    longint x;
    longint t;
    longint c;
    longint s;
    longint cr;
    longint sr;
    int     q;
    rom = '0;
    for (int k = 0; k < HALF; k++) begin
      q = ((32'sd4 * k) >= N_POINTS) ? 32'sd1 : 32'sd0;
      x = (PI_Q30 * 64'sd2 * longint'(k - q * (N_POINTS / 32'sd4))) / longint'(N_POINTS);
      c = ONE_Q30;
      t = ONE_Q30;
      for (int n = 1; n <= 12; n++) begin
        t = -((((t * x) >>> FRAC) * x) >>> FRAC) / longint'((32'sd2 * n - 32'sd1) * (32'sd2 * n));
        c = c + t;
      end
      s = x;
      t = x;
      for (int n = 1; n <= 12; n++) begin
        t = -((((t * x) >>> FRAC) * x) >>> FRAC) / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
        s = s + t;
      end
      cr = (c * (64'sd1 <<< (W_WIDTH - 2)) + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      sr = (s * (64'sd1 <<< (W_WIDTH - 2)) + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      if (q == 32'sd0) begin
        rom[k] = {W_WIDTH'(cr), W_WIDTH'(-sr)};
      end else begin
        rom[k] = {W_WIDTH'(-sr), W_WIDTH'(-cr)};
      end
    end
    return rom;
  endfunction

  localparam rom_t ROM = build_rom();

  logic [0:0]         state_r;
  logic [LOG2N-1:0]   stage_r;
  logic               inverse_r;
  logic [KW-1:0]      b_r;

  logic               stage_ok_s;
  logic               finish_s;
  logic               load_s;
  logic [LOG2N-1:0]   full_mask_s;
  logic [KW-1:0]      mask_s;
  logic [LOG2N-1:0]   shift_s;
  logic [KW-1:0]      k_s;
  logic [2*W_WIDTH-1:0] rom_word_s;
  logic [W_WIDTH-1:0] imag_s;

  // Handshake decode, exponent k = (b mod 2^s) << (LOG2N-1-s), and ROM lookup
  always_comb begin
    stage_ok_s  = ({1'b0, stage} < (LOG2N + 1)'(LOG2N));
    finish_s    = w_valid & w_ready & w_last;
    load_s      = (state_r == RUN) && (!w_valid || w_ready) && !(w_valid && w_last);
    full_mask_s = ({{KW{1'b0}}, 1'b1} << stage_r) - {{KW{1'b0}}, 1'b1};
    mask_s      = full_mask_s[KW-1:0];
    shift_s     = LOG2N'(KW) - stage_r;
    k_s         = (b_r & mask_s) << shift_s;
    rom_word_s  = ROM[k_s];
    if (inverse_r) begin
      imag_s = -rom_word_s[W_WIDTH-1:0];
    end else begin
      imag_s = rom_word_s[W_WIDTH-1:0];
    end
  end

  // Sequencer FSM and registered twiddle output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      stage_r   <= '0;
      inverse_r <= 1'b0;
      b_r       <= '0;
      w_valid   <= 1'b0;
      w_real    <= '0;
      w_imag    <= '0;
      w_index   <= '0;
      w_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && stage_ok_s) begin
            state_r   <= RUN;
            stage_r   <= stage;
            inverse_r <= inverse;
            b_r       <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (finish_s) begin
            state_r <= IDLE;
            b_r     <= '0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (load_s) begin
            w_real  <= rom_word_s[2*W_WIDTH-1:W_WIDTH];
            w_imag  <= imag_s;
            w_index <= k_s;
            w_last  <= &b_r;
            w_valid <= 1'b1;
            b_r     <= b_r + {{(KW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
          b_r     <= '0;
          w_valid <= 1'b0;
          w_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Directed bench for fft_twiddle_seq at N=8, W=16: stage orders, inverse mode,
// backpressure, illegal/overlapping starts and asynchronous abort.
module tb_fft_twiddle_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  stage;
  logic        inverse;
  logic        w_ready;
  logic        w_valid;
  logic signed [15:0] w_real;
  logic signed [15:0] w_imag;
  logic [1:0]  w_index;
  logic        w_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  fft_twiddle_seq #(.N_POINTS(8), .LOG2N(3), .W_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .inverse(inverse),
    .w_ready(w_ready), .w_valid(w_valid), .w_real(w_real), .w_imag(w_imag),
    .w_index(w_index), .w_last(w_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_word(input string tag, input int k, input int re, input int im, input logic last);
    chk({tag, " valid"}, 32'(w_valid), 32'd1);
    chk({tag, " index"}, 32'(w_index), k);
    chk({tag, " real"}, 32'($signed(w_real)), re);
    chk({tag, " imag"}, 32'($signed(w_imag)), im);
    chk({tag, " last"}, 32'(w_last), 32'(last));
  endtask

  // Full sequence with w_ready=1; entered and left on a falling edge
  task automatic run_seq(input string tag, input logic [2:0] st, input logic inv,
                         input int ks[4], input int res[4], input int ims[4]);
    start = 1'b1; stage = st; inverse = inv;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after start"}, 32'(busy), 32'd1);
    chk({tag, " no valid yet"}, 32'(w_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_word($sformatf("%s b%0d", tag, i), ks[i], res[i], ims[i], (i == 3));
    end
    @(negedge clk);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy end"}, 32'(busy), 32'd0);
    chk({tag, " valid end"}, 32'(w_valid), 32'd0);
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  int s2_k[4]  = '{0, 1, 2, 3};
  int s2_re[4] = '{16384, 11585, 0, -11585};
  int s2_im[4] = '{0, -11585, -16384, -11585};
  int s1_k[4]  = '{0, 2, 0, 2};
  int s1_re[4] = '{16384, 0, 16384, 0};
  int s1i_im[4] = '{0, 16384, 0, 16384};
  int s1f_im[4] = '{0, -16384, 0, -16384};
  int s0_k[4]  = '{0, 0, 0, 0};
  int s0_re[4] = '{16384, 16384, 16384, 16384};
  int s0_im[4] = '{0, 0, 0, 0};

  initial begin
    rst_n = 1'b0; start = 1'b0; stage = 3'd0; inverse = 1'b0; w_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset valid", 32'(w_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset real", 32'($signed(w_real)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq("s2fwd", 3'd2, 1'b0, s2_k, s2_re, s2_im);
    run_seq("s1inv", 3'd1, 1'b1, s1_k, s1_re, s1i_im);
    run_seq("s0", 3'd0, 1'b0, s0_k, s0_re, s0_im);

    // Backpressure: w_ready low for three cycles while b=1 is presented
    start = 1'b1; stage = 3'd2; inverse = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_word("bp b0", 0, 16384, 0, 1'b0);
    @(negedge clk);
    chk_word("bp b1", 1, 11585, -11585, 1'b0);
    w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_word($sformatf("bp hold%0d", i), 1, 11585, -11585, 1'b0);
      chk("bp no done", 32'(done), 32'd0);
    end
    w_ready = 1'b1;
    @(negedge clk);
    chk_word("bp b2", 2, 0, -16384, 1'b0);
    @(negedge clk);
    chk_word("bp b3", 3, -11585, -11585, 1'b1);
    @(negedge clk);
    chk("bp done", 32'(done), 32'd1);
    @(negedge clk);

    // Illegal stage is ignored
    start = 1'b1; stage = 3'd3;
    @(negedge clk);
    start = 1'b0;
    chk("illegal busy", 32'(busy), 32'd0);
    chk("illegal valid", 32'(w_valid), 32'd0);
    @(negedge clk);
    chk("illegal valid later", 32'(w_valid), 32'd0);

    // Start during RUN ignored; start in done cycle accepted back-to-back
    start = 1'b1; stage = 3'd2; inverse = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_word("ov b0", 0, 16384, 0, 1'b0);
    start = 1'b1; stage = 3'd1; inverse = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_word("ov b1", 1, 11585, -11585, 1'b0);
    @(negedge clk);
    chk_word("ov b2", 2, 0, -16384, 1'b0);
    @(negedge clk);
    chk_word("ov b3", 3, -11585, -11585, 1'b1);
    @(negedge clk);
    chk("ov done", 32'(done), 32'd1);
    start = 1'b1; stage = 3'd1; inverse = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b no valid yet", 32'(w_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_word($sformatf("b2b b%0d", i), s1_k[i], s1_re[i], s1f_im[i], (i == 3));
    end
    @(negedge clk);
    chk("b2b done", 32'(done), 32'd1);
    @(negedge clk);

    // Asynchronous abort mid-sequence, then a clean restart from b=0
    start = 1'b1; stage = 3'd2; inverse = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_word("abort pre b1", 1, 11585, -11585, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort valid", 32'(w_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort real", 32'($signed(w_real)), 32'd0);
    chk("abort imag", 32'($signed(w_imag)), 32'd0);
    chk("abort index", 32'(w_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort no done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort still no done", 32'(done), 32'd0);
    run_seq("restart", 3'd2, 1'b0, s2_k, s2_re, s2_im);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
